// File: rtl/dac_spi_out.sv
// dac_spi_out: serial output stage for the audio DAC.
// Frames each accepted 10-bit offset-binary sample as {CTRL_BITS, data, 2'b00},
// shifts it MSB first over SPI mode 0, then pulses LDAC so the analogue
// output updates once per sample.
//
// Ports:
//   sysclk   - system clock, rising edge
//   reset    - asynchronous active-high reset
//   tick     - one-cycle load strobe
//   data_in  - 10-bit sample, captured on the accepted tick
//   dac_cs_n - SPI chip select (active low)
//   dac_sck  - SPI clock, idles low
//   dac_sdi  - SPI data, MSB first
//   dac_ld_n - DAC latch strobe (active low)
//   busy     - frame in progress
//   overrun  - sticky: tick arrived while busy
module dac_spi_out #(
  parameter int         CLK_DIV   = 25,
  parameter logic [3:0] CTRL_BITS = 4'b0011
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       tick,
  input  logic [9:0] data_in,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld_n,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_LDAC
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        half_q, half_d;     // 0: SCK low half, 1: SCK high half
  logic [15:0] sreg_q, sreg_d;

  logic cs_n_q, cs_n_d;
  logic sck_q, sck_d;
  logic sdi_q, sdi_d;
  logic ld_n_q, ld_n_d;
  logic busy_q, busy_d;
  logic ovr_q, ovr_d;

  // A step ends each state/half after exactly CLK_DIV cycles.
  logic step;
  assign step = (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == S_IDLE) ? 8'd0 : 8'(cnt_q + 8'd1);
    bit_d   = bit_q;
    half_d  = half_q;
    sreg_d  = sreg_q;

    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          sreg_d  = {CTRL_BITS, data_in, 2'b00};
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (step) begin
          cnt_d   = 8'd0;
          bit_d   = 4'd0;
          half_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (step) begin
          cnt_d = 8'd0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            // End of the high half: advance data on the falling edge.
            half_d = 1'b0;
            sreg_d = {sreg_q[14:0], 1'b0};
            bit_d  = 4'(bit_q + 4'd1);
            if (bit_q == 4'd15) state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (step) begin
          cnt_d   = 8'd0;
          state_d = S_LDAC;
        end
      end
      S_LDAC: begin
        if (step) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    cs_n_d = !(state_d == S_SETUP || state_d == S_SHIFT || state_d == S_HOLD);
    sck_d  = (state_d == S_SHIFT) && half_d;
    sdi_d  = (state_d == S_SETUP || state_d == S_SHIFT) ? sreg_d[15] : 1'b0;
    ld_n_d = (state_d != S_LDAC);
    busy_d = (state_d != S_IDLE);
    // busy_q is the pre-edge busy, so a tick on the final LDAC edge counts.
    ovr_d  = ovr_q | (tick & busy_q);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      half_q  <= 1'b0;
      sreg_q  <= 16'd0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      sdi_q   <= 1'b0;
      ld_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      sreg_q  <= sreg_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      sdi_q   <= sdi_d;
      ld_n_q  <= ld_n_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dac_cs_n = cs_n_q;
  assign dac_sck  = sck_q;
  assign dac_sdi  = sdi_q;
  assign dac_ld_n = ld_n_q;
  assign busy     = busy_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_dac_spi_out.sv
// tb_dac_spi_out: bench for dac_spi_out. One fast instance (CLK_DIV=2) and
// one default instance (CLK_DIV=25), each checked every cycle against a
// timeline model derived from the frame start edge.
module tb_dac_spi_out;
  localparam int DF = 2;
  localparam int DD = 25;
  localparam logic [4:0] IDLE_PINS = 5'b10010; // {cs_n,sck,sdi,ld_n,busy}

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic rst_f = 1'b0, tick_f = 1'b0, rst_d = 1'b0, tick_d = 1'b0;
  logic [9:0] data_f = '0, data_d = '0;
  logic f_cs, f_sck, f_sdi, f_ld, f_busy, f_ovr;
  logic d_cs, d_sck, d_sdi, d_ld, d_busy, d_ovr;

  dac_spi_out #(.CLK_DIV(DF)) u_fast (
    .sysclk(sysclk), .reset(rst_f), .tick(tick_f), .data_in(data_f),
    .dac_cs_n(f_cs), .dac_sck(f_sck), .dac_sdi(f_sdi), .dac_ld_n(f_ld),
    .busy(f_busy), .overrun(f_ovr));

  dac_spi_out u_dflt (
    .sysclk(sysclk), .reset(rst_d), .tick(tick_d), .data_in(data_d),
    .dac_cs_n(d_cs), .dac_sck(d_sck), .dac_sdi(d_sdi), .dac_ld_n(d_ld),
    .busy(d_busy), .overrun(d_ovr));

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pin values t cycles after the accepting edge, straight from the frame
  // timeline: SETUP [0,D), bit k occupies [D+2kD, D+2(k+1)D) with SCK high in
  // its second half, HOLD [33D,34D), LDAC [34D,35D).
  function automatic logic [4:0] exp_pins(input int t, input int D, input logic [15:0] w);
    logic cs_n, sck, sdi, ld_n;
    if (t < 0 || t >= 35*D) return IDLE_PINS;
    cs_n = (t >= 34*D);
    sck  = (t >= 2*D) && (t < 34*D) && (((t / D) % 2) == 0);
    if (t < D)          sdi = w[15];
    else if (t < 33*D)  sdi = w[15 - ((t - D) / (2*D))];
    else                sdi = 1'b0;
    ld_n = !((t >= 34*D) && (t < 35*D));
    return {cs_n, sck, sdi, ld_n, 1'b1};
  endfunction

  // ---------------- reference model: fast instance ----------------
  int e_f = 0, n_f = 0;
  bit act_f = 0, ovr_f = 0;
  logic [15:0] w_f = '0;
  always @(posedge sysclk or posedge rst_f) begin
    if (rst_f) begin
      act_f <= 0; ovr_f <= 0;
    end else begin
      e_f <= e_f + 1;
      if (tick_f) begin
        if (act_f && (e_f - n_f) < 35*DF) ovr_f <= 1;
        else begin
          act_f <= 1; n_f <= e_f + 1; w_f <= {4'b0011, data_f, 2'b00};
        end
      end
    end
  end

  always @(negedge sysclk) if (cmp_en)
    check("fast_pins", {f_cs, f_sck, f_sdi, f_ld, f_busy, f_ovr},
          {(act_f ? exp_pins(e_f - n_f, DF, w_f) : IDLE_PINS), ovr_f});

  // ---------------- reference model: default instance ----------------
  int e_d = 0, n_d = 0;
  bit act_d = 0, ovr_m_d = 0;
  logic [15:0] w_d = '0;
  always @(posedge sysclk or posedge rst_d) begin
    if (rst_d) begin
      act_d <= 0; ovr_m_d <= 0;
    end else begin
      e_d <= e_d + 1;
      if (tick_d) begin
        if (act_d && (e_d - n_d) < 35*DD) ovr_m_d <= 1;
        else begin
          act_d <= 1; n_d <= e_d + 1; w_d <= {4'b0011, data_d, 2'b00};
        end
      end
    end
  end

  always @(negedge sysclk) if (cmp_en)
    check("dflt_pins", {d_cs, d_sck, d_sdi, d_ld, d_busy, d_ovr},
          {(act_d ? exp_pins(e_d - n_d, DD, w_d) : IDLE_PINS), ovr_m_d});

  // ---------------- pin monitors (monotonic counters) ----------------
  logic [15:0] cap_f = '0, cap_d = '0;
  int pul_f = 0, pul_d = 0, csl_f = 0, ldl_f = 0, ldok_f = 0, per_ok_d = 0;
  logic prev_cs_f = 1'b1;
  realtime last_rise_d = 0;
  always @(posedge f_sck) begin cap_f <= {cap_f[14:0], f_sdi}; pul_f <= pul_f + 1; end
  always @(posedge d_sck) begin
    cap_d <= {cap_d[14:0], d_sdi}; pul_d <= pul_d + 1;
    if ($realtime - last_rise_d == 500.0) per_ok_d <= per_ok_d + 1;
    last_rise_d <= $realtime;
  end
  always @(negedge sysclk) begin
    if (!f_cs) csl_f <= csl_f + 1;
    if (!f_ld) ldl_f <= ldl_f + 1;
    if (!f_ld && f_cs && !prev_cs_f) ldok_f <= ldok_f + 1;
    prev_cs_f <= f_cs;
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_f(input logic [9:0] v);
    @(negedge sysclk); data_f = v; tick_f = 1'b1;
    @(negedge sysclk); tick_f = 1'b0;
  endtask

  task automatic wait_idle_f(input bit scramble);
    int k = 0;
    while (f_busy && k < 400) begin
      if (scramble) data_f = 10'($urandom);
      @(negedge sysclk); k++;
    end
    check("fast_busy_timeout", 32'(k < 400), 32'd1);
    repeat (3) @(negedge sysclk);
  endtask

  task automatic pulse_reset_f();
    @(negedge sysclk); rst_f = 1'b1;
    @(negedge sysclk); rst_f = 1'b0;
  endtask

  int b_pul, b_csl, b_ldl, b_ok;
  task automatic base_f();
    b_pul = pul_f; b_csl = csl_f; b_ldl = ldl_f; b_ok = ldok_f;
  endtask

  task automatic frame_checks(input string tag, input logic [15:0] expw);
    check({tag, "_word"},   32'(cap_f), 32'(expw));
    check({tag, "_pulses"}, pul_f - b_pul, 16);
    check({tag, "_cs_low"}, csl_f - b_csl, 68);
    check({tag, "_ld_low"}, ldl_f - b_ldl, 2);
    check({tag, "_ld_at_cs_rise"}, ldok_f - b_ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] v;
    int tog, bc, bp, bo;

    #1 rst_f = 1'b1; rst_d = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (3) @(negedge sysclk);
    rst_f = 1'b0; rst_d = 1'b0;

    check("reset_fast", {f_cs, f_sck, f_sdi, f_ld, f_busy, f_ovr}, 6'b100100);
    check("reset_dflt", {d_cs, d_sck, d_sdi, d_ld, d_busy, d_ovr}, 6'b100100);

    // Idle for 100 cycles: nothing moves.
    tog = 0;
    repeat (100) begin
      @(negedge sysclk);
      if ({f_cs, f_sck, f_sdi, f_ld, f_busy, f_ovr} !== 6'b100100) tog++;
    end
    check("idle_quiet", tog, 0);

    // Basic frame.
    base_f(); start_f(10'h2A5); wait_idle_f(1'b0);
    frame_checks("frame_2A5", 16'h3A94);

    // data_in scrambled every cycle after the tick.
    v = 10'($urandom);
    base_f(); start_f(v); wait_idle_f(1'b1);
    frame_checks("frame_scrambled", {4'b0011, v, 2'b00});

    // Second tick 10 cycles into a frame.
    base_f(); start_f(10'h155);
    repeat (9) @(negedge sysclk);
    data_f = 10'h0AA; tick_f = 1'b1;
    @(negedge sysclk); tick_f = 1'b0;
    check("overrun_set", 32'(f_ovr), 32'd1);
    wait_idle_f(1'b0);
    frame_checks("frame_ovr", 16'h3554);
    repeat (20) @(negedge sysclk);
    check("overrun_sticky", 32'(f_ovr), 32'd1);
    base_f(); start_f(10'h0F0); wait_idle_f(1'b0);
    frame_checks("frame_after_ovr", 16'h33C0);
    check("overrun_still", 32'(f_ovr), 32'd1);

    // Tick on the edge busy falls is an overrun; one edge later is accepted.
    pulse_reset_f();
    start_f(10'h001);
    repeat (35*DF - 1) @(negedge sysclk);
    tick_f = 1'b1; @(negedge sysclk); tick_f = 1'b0;
    check("boundary_overrun", 32'(f_ovr), 32'd1);
    check("boundary_dropped", 32'(f_busy), 32'd0);
    pulse_reset_f();
    start_f(10'h001);
    repeat (35*DF) @(negedge sysclk);
    tick_f = 1'b1; @(negedge sysclk); tick_f = 1'b0;
    check("boundary_accept_ovr", 32'(f_ovr), 32'd0);
    check("boundary_accept_busy", 32'(f_busy), 32'd1);
    wait_idle_f(1'b0);

    // Random tick traffic.
    repeat (3000) begin
      @(negedge sysclk);
      tick_f = ($urandom_range(0, 59) == 0);
      data_f = 10'($urandom);
    end
    tick_f = 1'b0;
    wait_idle_f(1'b0);

    // Asynchronous reset mid-SHIFT.
    pulse_reset_f();
    base_f(); start_f(10'h1C3);
    repeat (20) @(negedge sysclk);
    @(posedge sysclk); #3 rst_f = 1'b1;
    #1 check("async_reset_idle", {f_cs, f_sck, f_sdi, f_ld, f_busy, f_ovr}, 6'b100100);
    @(negedge sysclk); #2 rst_f = 1'b0;
    repeat (5) @(negedge sysclk);
    check("async_reset_no_ld", ldl_f - b_ldl, 0);
    base_f(); start_f(10'h3FF); wait_idle_f(1'b0);
    frame_checks("frame_3FF", 16'h3FFC);

    // Default divider: ten ticks every 5000 cycles.
    for (int i = 0; i < 10; i++) begin
      bp = pul_d; bo = per_ok_d;
      @(negedge sysclk); data_d = 10'(i); tick_d = 1'b1;
      @(negedge sysclk); tick_d = 1'b0;
      bc = 0;
      while (d_busy && bc < 2000) begin bc++; @(negedge sysclk); end
      check("dflt_frame_len", bc, 875);
      repeat (3) @(negedge sysclk);
      check("dflt_word", 32'(cap_d), 32'({4'b0011, 10'(i), 2'b00}));
      check("dflt_pulses", pul_d - bp, 16);
      check("dflt_sck_period", per_ok_d - bo, 15);
      repeat (5000 - 5 - bc) @(negedge sysclk);
    end
    check("dflt_no_overrun", 32'(d_ovr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_spi_out.md
# dac_spi_out

Serial DAC output stage for the 10 kHz audio path. Accepts the registered 10-bit offset-binary sample from the processing stage on each `tick`, frames it into a 16-bit MCP4911 write command, and shifts it out over SPI (mode 0), followed by an LDAC strobe so the analogue output updates once per sample. It sits directly downstream of the delay/echo processor and drives the DAC pins.

## Interface
- `CLK_DIV`, 25: sysclk cycles per SCK half-period (25 gives 1 MHz SCK at 50 MHz); legal range 2..255.
- `CTRL_BITS`, 4'b0011: command nibble, word bits 15:12 (write, unbuffered, 1x gain, active).
- `sysclk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; forces idle state and idle output values.
- `tick` in 1: one-cycle load strobe, 10 kHz.
- `data_in` in 10: offset-binary sample, sampled on the accepted `tick` edge.
- `dac_cs_n` out 1: SPI chip select, active low.
- `dac_sck` out 1: SPI clock, idle low.
- `dac_sdi` out 1: SPI data, MSB first.
- `dac_ld_n` out 1: DAC latch strobe, active low.
- `busy` out 1: high from an accepted tick until the frame completes.
- `overrun` out 1: sticky; set when a tick arrives while busy.

## Operation
- Frame word: `{CTRL_BITS, data_in[9:0], 2'b00}`, latched into a 16-bit shift register on acceptance. Later changes to `data_in` do not affect the frame in flight.
- Half-period counter runs 0..CLK_DIV-1 while not IDLE and is cleared on every state change. A "step" occurs on the edge where the counter reaches CLK_DIV-1.
- States:
  - IDLE: cs_n=1, sck=0, sdi=0, ld_n=1, busy=0. If `tick`=1, latch the word, set busy, and go to SETUP.
  - SETUP: cs_n=0, sdi=word[15]. Lasts one step, then goes to SHIFT.
  - SHIFT: 16 bits, each 2 steps long. SCK is low for the first step and high for the second. At the end of each high half, the register shifts left and the bit count increments. After bit 15's high half, SCK returns to 0 and the state goes to HOLD.
  - HOLD: cs_n=0, sck=0. Lasts one step, then goes to LDAC.
  - LDAC: cs_n=1, ld_n=0. Lasts one step, then returns to IDLE with busy=0.
- `dac_sdi` changes only while SCK is low or on the falling edge, so data is stable across each SCK rising edge.
- A tick seen while busy=1 (sampled before the edge) is dropped and sets `overrun`. Only `reset` clears `overrun`.
- A reset mid-frame abandons the frame. `ld_n` stays high, so the DAC keeps its previous value.

## Timing
- All outputs are registered. Reset values: cs_n=1, sck=0, sdi=0, ld_n=1, busy=0, overrun=0.
- For a tick accepted at edge n (D = CLK_DIV):
  - cs_n falls and busy rises at edge n.
  - SCK rising edge for bit k (k=0 is the MSB) at n+(2+2k)·D; the matching falling edge at n+(3+2k)·D.
  - cs_n rises at n+34·D. ld_n is low from n+34·D to n+35·D.
  - busy falls at n+35·D.
- Frame length is 35·D cycles (875 at default, 17.5 µs), well under the 5000-cycle tick period.
- The earliest next accepted tick is at edge n+35·D+1. A tick at edge n+35·D itself is an overrun.

## Test plan
- Reset then idle, CLK_DIV=2: all outputs at reset values; with no tick for 100 cycles, no pin toggles.
- data_in=10'h2A5, tick: capture 16 bits on SCK rising edges and check the word equals 16'h3A94. Check exactly 16 SCK pulses, cs_n low for 68 cycles, and ld_n low for 2 cycles starting as cs_n rises.
- data_in changed every cycle after the tick: the serialized word still matches the value present at the tick edge.
- A second tick 10 cycles into the frame: frame unaffected, `overrun`=1 and stays 1. Next tick after busy falls: a normal frame is sent and `overrun` remains 1.
- Reset asserted asynchronously mid-SHIFT (between clock edges): outputs go idle immediately, no ld_n pulse. After reset releases, a tick with 10'h3FF produces 16'h3FFC.
- Default CLK_DIV=25, ten back-to-back ticks every 5000 cycles with values 0..9: ten frames each of 875 cycles, SCK period 50 cycles, `overrun`=0.
